nyq_frame_seq: RTL
==================

Name: nyq_frame_seq

Overview:
- Controller for the NYQ sample buffer. Sequences one frame: capture 2^ADDR_W input samples into a single-port buffer RAM, then drain them in capture order over a valid/ready stream.
- Owns the buffer's down-counting address generator. Memory writes and reads are issued only from this block.
- Sits between the NYQ sample source and the downstream consumer. The RAM is external; its read latency is 1 cycle.

Parameters:
- ADDR_W, 8, buffer address width; frame length N = 2^ADDR_W.
- DATA_W, 16, sample width.

Ports:
- Clk_CI  in  1  clock
- Rst_RBI  in  1  reset; asynchronous, active-low
- Start_SI  in  1  single-cycle request to begin a frame; ignored unless IDLE
- Abort_SI  in  1  synchronous abort; return to IDLE
- SmpValid_SI  in  1  input sample strobe
- SmpData_DI  in  DATA_W  input sample
- MemWrEn_SO  out  1  RAM write enable
- MemRdEn_SO  out  1  RAM read enable
- MemAddr_DO  out  ADDR_W  RAM address, shared by reads and writes
- MemWrData_DO  out  DATA_W  RAM write data (= SmpData_DI)
- MemRdData_DI  in  DATA_W  RAM read data, valid 1 cycle after MemRdEn_SO
- OutValid_SO  out  1  output sample valid
- OutReady_SI  in  1  consumer ready
- OutData_DO  out  DATA_W  output sample
- Busy_SO  out  1  state != IDLE
- Done_SO  out  1  1-cycle pulse when the frame completes
- Overrun_SO  out  1  sticky flag: sample dropped

Behaviour:
- Reset values: state IDLE, address counter 2^ADDR_W-1, OutValid_SO=0, OutData_DO=0, Done_SO=0, Overrun_SO=0, RdPending=0. All memory enables are 0.
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - Start_SI=1 -> CAPTURE. Counter is loaded with 2^ADDR_W-1 and Overrun_SO is cleared.
  - SmpValid_SI is ignored and does not set overrun.
- CAPTURE:
  - MemWrEn_SO = SmpValid_SI (combinational), MemAddr_DO = counter.
  - Each accepted sample decrements the counter.
  - A write at address 0 -> DRAIN next cycle, and the counter reloads to 2^ADDR_W-1.
  - There is no wrap inside CAPTURE.
- DRAIN:
  - Read issue condition: MemRdEn_SO = !RdDone & (!RdPending | !OutValid_SO | OutReady_SI) & (!OutValid_SO | OutReady_SI). When it fires, MemAddr_DO = counter, the counter decrements, and RdPending is set for 1 cycle.
  - Data returned the cycle after a read loads OutData_DO and sets OutValid_SO.
  - OutValid_SO/OutData_DO hold stable until OutReady_SI=1. Valid must never drop without a handshake.
  - The issue condition allows sustained 1 sample/cycle when OutReady_SI is held high.
  - RdDone is set after the read of address 0 is issued.
  - After the handshake of the last sample (the read from address 0): Done_SO pulses 1 cycle and the state goes to IDLE. Busy_SO falls in the same cycle that Done_SO is high.
  - SmpValid_SI=1 in DRAIN: the sample is dropped and Overrun_SO is set; it stays set until the next accepted Start_SI.
- Output order equals capture order: write address k is read as the (N-k)th output.
- Abort_SI (any state) has priority over all other inputs that cycle. Next cycle: IDLE, OutValid_SO=0, RdPending=0, counter reloaded, no Done_SO pulse, and no memory enable in the abort cycle. Overrun_SO is not cleared.
- Start_SI together with Abort_SI: the abort wins and Start_SI is dropped.
- Reset mid-frame: immediate return to reset values; RAM contents are undefined to the block.
- Counter arithmetic is modulo 2^ADDR_W. The reload is explicit, never relying on underflow.

Decomposition:
- Shared package nyq_pkg: state enum (IDLE/CAPTURE/DRAIN), default ADDR_W/DATA_W constants.
- One sub-module, nyq_addr_cnt: ADDR_W down-counter with synchronous load-to-max, decrement enable and a zero flag; async reset to max.
- FSM, read pipeline and output register live in nyq_frame_seq.

Test Plan (ADDR_W=3, N=8):
- Reset, then Start, then 8 samples 0x10..0x17 on consecutive cycles -> writes to addr 7..0; DRAIN entered the cycle after the addr-0 write; OutReady=1 gives outputs 0x10..0x17 on 8 consecutive cycles; Done pulses once; Busy falls.
- Same frame with OutReady toggling 1,0,0,1 -> no sample lost or duplicated, OutData stable while stalled, order 0x10..0x17.
- SmpValid held high in DRAIN for 3 cycles -> Overrun=1; output data unaffected; next Start clears Overrun.
- Abort after 4 captured samples -> IDLE next cycle, no Done; new Start captures a full 8-sample frame starting at addr 7.
- Abort in DRAIN with OutValid=1 and OutReady=0 -> OutValid drops next cycle, no MemRdEn afterwards; Start plus Abort in the same cycle -> stays IDLE.
- Rst_RBI asserted mid-CAPTURE, asynchronously between edges -> outputs go to reset values immediately; Start ignored while in CAPTURE/DRAIN (no counter reload).

Source files
------------

// File: rtl/nyq_pkg.sv
// Shared types and default sizes for the NYQ sample-buffer frame sequencer.
package nyq_pkg;

    localparam int unsigned NYQ_ADDR_W = 8;
    localparam int unsigned NYQ_DATA_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StDrain
    } nyq_state_e;

endpackage

// File: rtl/nyq_addr_cnt.sv
// Buffer address down-counter: synchronous load-to-max, decrement enable, zero flag.
module nyq_addr_cnt #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              Load_SI,
    input  logic              Dec_SI,
    output logic [ADDR_W-1:0] Cnt_DO,
    output logic              Zero_SO
);

    logic [ADDR_W-1:0] cnt_d, cnt_q;

    // Load wins over decrement so the wrap from 0 is always an explicit reload.
    always_comb begin
        cnt_d = cnt_q;
        if (Load_SI) begin
            cnt_d = '1;
        end else if (Dec_SI) begin
            cnt_d = cnt_q - ADDR_W'(1);
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            cnt_q <= '1;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Cnt_DO  = cnt_q;
    assign Zero_SO = (cnt_q == '0);

endmodule

// File: rtl/nyq_frame_seq.sv
// NYQ frame sequencer: captures 2^ADDR_W samples into the buffer RAM, then drains
// them in capture order over a valid/ready stream.
module nyq_frame_seq
    import nyq_pkg::*;
#(
    parameter int unsigned ADDR_W = NYQ_ADDR_W,
    parameter int unsigned DATA_W = NYQ_DATA_W
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              Start_SI,
    input  logic              Abort_SI,
    input  logic              SmpValid_SI,
    input  logic [DATA_W-1:0] SmpData_DI,
    output logic              MemWrEn_SO,
    output logic              MemRdEn_SO,
    output logic [ADDR_W-1:0] MemAddr_DO,
    output logic [DATA_W-1:0] MemWrData_DO,
    input  logic [DATA_W-1:0] MemRdData_DI,
    output logic              OutValid_SO,
    input  logic              OutReady_SI,
    output logic [DATA_W-1:0] OutData_DO,
    output logic              Busy_SO,
    output logic              Done_SO,
    output logic              Overrun_SO
);

    nyq_state_e state_d, state_q;

    logic              rd_pending_d, rd_pending_q;
    logic              rd_done_d, rd_done_q;
    logic              out_valid_d, out_valid_q;
    logic [DATA_W-1:0] out_data_d, out_data_q;
    logic              skid_valid_d, skid_valid_q;
    logic [DATA_W-1:0] skid_data_d, skid_data_q;
    logic              done_d, done_q;
    logic              overrun_d, overrun_q;

    logic              mem_wr_en, mem_rd_en, busy;
    logic              start_acc, last_hs;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [ADDR_W-1:0] cnt;

    nyq_addr_cnt #(
        .ADDR_W (ADDR_W)
    ) u_addr_cnt (
        .Clk_CI  (Clk_CI),
        .Rst_RBI (Rst_RBI),
        .Load_SI (cnt_load),
        .Dec_SI  (cnt_dec),
        .Cnt_DO  (cnt),
        .Zero_SO (cnt_zero)
    );

    assign start_acc = (state_q == StIdle) & Start_SI & ~Abort_SI;
    // Final handshake: address 0 already read and nothing left in flight.
    assign last_hs   = (state_q == StDrain) & ~Abort_SI & out_valid_q & OutReady_SI
                     & rd_done_q & ~rd_pending_q & ~skid_valid_q;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (Abort_SI) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:    if (Start_SI) state_d = StCapture;
                StCapture: if (mem_wr_en && cnt_zero) state_d = StDrain;
                StDrain:   if (last_hs) state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            StIdle:    busy = 1'b0;
            StCapture: mem_wr_en = SmpValid_SI & ~Abort_SI;
            StDrain:   mem_rd_en = ~Abort_SI & ~rd_done_q
                                 & (~rd_pending_q | ~out_valid_q | OutReady_SI)
                                 & (~out_valid_q | OutReady_SI);
            default:   busy = 1'b0;
        endcase
    end

    always_comb begin
        cnt_load = Abort_SI | start_acc | ((mem_wr_en | mem_rd_en) & cnt_zero);
        cnt_dec  = mem_wr_en | mem_rd_en;
    end

    // A read issued while the output drains can land on a stalled output
    // register; the skid slot holds it so RAM data is consumed the cycle it
    // appears.
    always_comb begin
        rd_pending_d = mem_rd_en;
        done_d       = last_hs;
        rd_done_d    = rd_done_q;
        overrun_d    = overrun_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (Abort_SI || start_acc || last_hs) begin
            rd_done_d = 1'b0;
        end else if (mem_rd_en && cnt_zero) begin
            rd_done_d = 1'b1;
        end

        if (start_acc) begin
            overrun_d = 1'b0;
        end else if ((state_q == StDrain) && SmpValid_SI && !Abort_SI) begin
            overrun_d = 1'b1;
        end

        if (Abort_SI) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || OutReady_SI) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = rd_pending_q;
                if (rd_pending_q) skid_data_d = MemRdData_DI;
            end else if (rd_pending_q) begin
                out_valid_d = 1'b1;
                out_data_d  = MemRdData_DI;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (rd_pending_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = MemRdData_DI;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            rd_pending_q <= 1'b0;
            rd_done_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rd_pending_q <= rd_pending_d;
            rd_done_q    <= rd_done_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign MemWrEn_SO   = mem_wr_en;
    assign MemRdEn_SO   = mem_rd_en;
    assign MemAddr_DO   = cnt;
    assign MemWrData_DO = SmpData_DI;
    assign OutValid_SO  = out_valid_q;
    assign OutData_DO   = out_data_q;
    assign Busy_SO      = busy;
    assign Done_SO      = done_q;
    assign Overrun_SO   = overrun_q;

endmodule
